photon_dispatch: RTL and testbench

PHOTON_DISPATCH -- requirements
Module: photon_dispatch

---
 rtl/mclp_pkg.sv | 26 ++
 rtl/mclp_lfsr32.sv | 25 ++
 rtl/photon_dispatch.sv | 146 ++++++++++++++
 tb/tb_photon_dispatch.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mclp_pkg.sv
// Shared types and constants for the photon dispatch block.
// The dispatch FSM state encoding, the unit photon weight and the
// LFSR feedback polynomial live here so the top level, the LFSR
// sub-module and any future core-side logic agree on them.
package mclp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } dispatch_state_t;

    // Q1.31 representation of 1.0: every photon starts at full weight.
    localparam logic [31:0] WEIGHT_ONE = 32'h8000_0000;

    // Feedback taps of the 32-bit Galois LFSR used for per-photon seeds.
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // One right-shifting Galois step: when the bit falling off the
    // bottom is set, the polynomial taps are folded back in.
    function automatic logic [31:0] lfsr_advance(input logic [31:0] cur);
        lfsr_advance = {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/mclp_lfsr32.sv
// 32-bit Galois LFSR that supplies per-photon RNG seeds.
// Only instantiated by photon_dispatch when PHOTON_DISPATCH_SEED_EN
// is defined. The value advances exactly once per accepted launch,
// so each photon sees a distinct seed; only reset reloads it.
module mclp_lfsr32
    import mclp_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_0001
) (
    input  logic        sys_clock,
    input  logic        reset_rtl,
    input  logic        step,
    output logic [31:0] value
);

    // Reload the seed on reset, otherwise advance one step per launch.
    always_ff @(posedge sys_clock) begin
        if (reset_rtl) begin
            value <= SEED;
        end else if (step) begin
            value <= lfsr_advance(value);
        end
    end

endmodule

// File: rtl/photon_dispatch.sv
// Photon dispatch: hands out launch tokens for a Monte Carlo run.
// A run is requested with a start pulse carrying the photon count.
// Tokens (id, weight and optionally a seed) are offered to the
// propagation core with a valid/ready handshake, while the number of
// photons launched but not yet retired is capped at MAX_INFLIGHT.
// Once every photon is launched the block waits for all of them to
// retire, then reports done until the next run is accepted.
// Optional feature: define PHOTON_DISPATCH_SEED_EN to add the
// launch_seed output driven by a 32-bit Galois LFSR.
module photon_dispatch
    import mclp_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 16,
    parameter logic [31:0] WEIGHT_INIT  = WEIGHT_ONE,
    parameter logic [31:0] SEED_INIT    = 32'hACE1_0001
) (
    input  logic                          sys_clock,
    input  logic                          reset_rtl,
    input  logic                          start,
    input  logic [31:0]                   num_photons,
    output logic                          launch_valid,
    input  logic                          launch_ready,
    output logic [31:0]                   launch_id,
    output logic [31:0]                   launch_weight,
`ifdef PHOTON_DISPATCH_SEED_EN
    output logic [31:0]                   launch_seed,
`endif
    input  logic                          retire,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          busy,
    output logic                          done,
    output logic                          err_underflow
);

    localparam int unsigned IW = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [IW-1:0] INFLIGHT_CAP = IW'(MAX_INFLIGHT);

    dispatch_state_t state;
    logic [31:0]     total;
    logic [31:0]     issued;
    logic [IW-1:0]   inflight_q;
    logic            err_q;

    logic start_ok;
    logic transfer;
    logic retire_ok;
    logic retire_bad;
    logic last_xfer;

    // A new run may only begin while nothing is in flight from the
    // dispatcher's point of view (idle or finished).
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

    // Offer a token only while launching and below the in-flight cap.
    // Because inflight only grows on a transfer, a raised valid cannot
    // drop before the core takes the token.
    assign launch_valid = (state == ST_LAUNCH) && (inflight_q < INFLIGHT_CAP);
    assign transfer     = launch_valid && launch_ready;

    // A retire is only meaningful when something is outstanding; any
    // other retire is a core-side protocol error.
    assign retire_ok  = retire && (inflight_q != '0);
    assign retire_bad = retire && (inflight_q == '0);

    assign last_xfer = transfer && (issued == (total - 32'd1));

    assign launch_id     = issued;
    assign launch_weight = WEIGHT_INIT;
    assign inflight      = inflight_q;
    assign busy          = (state == ST_LAUNCH) || (state == ST_DRAIN);
    assign done          = (state == ST_DONE);
    assign err_underflow = err_q;

    // Track outstanding photons and the sticky underflow flag. A launch
    // and a retire in the same cycle cancel out; a stray retire leaves
    // the count at zero. Starting a new run clears the error.
    always_ff @(posedge sys_clock) begin
        if (reset_rtl) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (transfer && !retire_ok) begin
                inflight_q <= inflight_q + IW'(1);
            end else if (!transfer && retire_ok) begin
                inflight_q <= inflight_q - IW'(1);
            end

            if (start_ok) begin
                err_q <= 1'b0;
            end else if (retire_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    // Run sequencing: latch the run size, issue ids until the last one
    // is accepted, wait for the core to drain, then hold done.
    always_ff @(posedge sys_clock) begin
        if (reset_rtl) begin
            state  <= ST_IDLE;
            total  <= '0;
            issued <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        total  <= num_photons;
                        issued <= '0;
                        state  <= (num_photons == 32'd0) ? ST_DONE : ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (transfer) begin
                        issued <= issued + 32'd1;
                        if (last_xfer) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (inflight_q == '0) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PHOTON_DISPATCH_SEED_EN
    mclp_lfsr32 #(
        .SEED(SEED_INIT)
    ) u_lfsr (
        .sys_clock (sys_clock),
        .reset_rtl (reset_rtl),
        .step      (transfer),
        .value     (launch_seed)
    );
`else
    logic seed_unused;
    assign seed_unused = ^SEED_INIT;
`endif

endmodule

// File: tb/tb_photon_dispatch.sv
// Testbench for photon_dispatch.
// Expected launch ids are queued when a run is requested and popped
// whenever the DUT completes a launch handshake. With
// PHOTON_DISPATCH_SEED_EN defined, seeds are checked against an
// independent LFSR reference.
module tb_photon_dispatch;

    localparam int unsigned MAXI = 16;
    localparam int unsigned IW   = $clog2(MAXI) + 1;
    localparam logic [31:0] REF_POLY = 32'h8020_0003;
    localparam logic [31:0] REF_SEED = 32'hACE1_0001;

    logic          sys_clock = 1'b0;
    logic          reset_rtl = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   num_photons = '0;
    logic          launch_valid;
    logic          launch_ready = 1'b0;
    logic [31:0]   launch_id;
    logic [31:0]   launch_weight;
`ifdef PHOTON_DISPATCH_SEED_EN
    logic [31:0]   launch_seed;
`endif
    logic          retire = 1'b0;
    logic [IW-1:0] inflight;
    logic          busy;
    logic          done;
    logic          err_underflow;

    int tests = 0;
    int failures = 0;

    logic [31:0] exp_id_q[$];
    logic [31:0] model_seed = REF_SEED;
    int          xfer_count = 0;
    int          edge_no = 0;
    int          first_xfer_edge = -1;
    int          last_xfer_edge = -1;
    int          last_retire_edge = -1;
    bit          auto_retire = 1'b0;
    logic [2:0]  rpipe = '0;

    photon_dispatch #(
        .MAX_INFLIGHT (MAXI),
        .WEIGHT_INIT  (32'h8000_0000),
        .SEED_INIT    (REF_SEED)
    ) dut (
        .sys_clock     (sys_clock),
        .reset_rtl     (reset_rtl),
        .start         (start),
        .num_photons   (num_photons),
        .launch_valid  (launch_valid),
        .launch_ready  (launch_ready),
        .launch_id     (launch_id),
        .launch_weight (launch_weight),
`ifdef PHOTON_DISPATCH_SEED_EN
        .launch_seed   (launch_seed),
`endif
        .retire        (retire),
        .inflight      (inflight),
        .busy          (busy),
        .done          (done),
        .err_underflow (err_underflow)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock. Any handshake visible now completes at the
    // coming edge, so it is scored against the queue here.
    task automatic tick();
        logic xfer;
        xfer = launch_valid && launch_ready;
        if (xfer) begin
            check_output("transfer_expected", 32'(exp_id_q.size() != 0), 32'd1);
            if (exp_id_q.size() != 0) begin
                check_output("launch_id", launch_id, exp_id_q.pop_front());
            end
`ifdef PHOTON_DISPATCH_SEED_EN
            check_output("launch_seed", launch_seed, model_seed);
            model_seed = (model_seed >> 1) ^ (model_seed[0] ? REF_POLY : 32'h0);
`endif
            xfer_count++;
            if (first_xfer_edge < 0) first_xfer_edge = edge_no + 1;
            last_xfer_edge = edge_no + 1;
        end
        if (auto_retire) begin
            retire = rpipe[2];
            rpipe  = {rpipe[1:0], xfer};
            if (retire) last_retire_edge = edge_no + 1;
        end
        @(posedge sys_clock);
        #1;
        edge_no++;
    endtask

    task automatic stop_auto();
        auto_retire = 1'b0;
        rpipe = '0;
        retire = 1'b0;
    endtask

    task automatic apply_start(input logic [31:0] n, input bit accept);
        start = 1'b1;
        num_photons = n;
        if (accept) begin
            for (int i = 0; i < int'(n); i++) exp_id_q.push_back(32'(i));
        end
        tick();
        start = 1'b0;
        num_photons = $urandom;
    endtask

    task automatic apply_reset(input int cycles);
        launch_ready = 1'b0;
        stop_auto();
        reset_rtl = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        reset_rtl = 1'b0;
        exp_id_q.delete();
        model_seed = REF_SEED;
    endtask

    task automatic run_to_done(input int bound);
        int n;
        n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        check_output("done_reached", 32'(done), 32'd1);
    endtask

    task automatic clear_stats();
        xfer_count = 0;
        first_xfer_edge = -1;
        last_xfer_edge = -1;
        last_retire_edge = -1;
    endtask

    initial begin
        int s_edge;

        // Reset state
        apply_reset(2);
        check_output("rst_valid", 32'(launch_valid), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_err", 32'(err_underflow), 32'd0);
        check_output("rst_inflight", 32'(inflight), 32'd0);
        check_output("rst_id", launch_id, 32'd0);
        check_output("weight", launch_weight, 32'h8000_0000);

        // Five photons, core always ready, retire 3 cycles after launch
        clear_stats();
        launch_ready = 1'b1;
        auto_retire = 1'b1;
        apply_start(32'd5, 1'b1);
        s_edge = edge_no;
        check_output("run5_busy", 32'(busy), 32'd1);
        check_output("run5_valid_c1", 32'(launch_valid), 32'd1);
        run_to_done(60);
        check_output("run5_xfers", 32'(xfer_count), 32'd5);
        check_output("run5_first_edge", 32'(first_xfer_edge), 32'(s_edge + 1));
        check_output("run5_last_edge", 32'(last_xfer_edge), 32'(s_edge + 5));
        check_output("run5_done_lat", 32'(edge_no), 32'(last_retire_edge + 1));
        check_output("run5_sb_empty", 32'(exp_id_q.size()), 32'd0);
        check_output("run5_inflight", 32'(inflight), 32'd0);
        check_output("run5_busy_end", 32'(busy), 32'd0);
        stop_auto();
        tick();
        check_output("run5_done_held", 32'(done), 32'd1);

        // Backpressure: ready low for 10 cycles, token must hold still
        clear_stats();
        launch_ready = 1'b0;
        auto_retire = 1'b1;
        apply_start(32'd3, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check_output("bp_valid", 32'(launch_valid), 32'd1);
            check_output("bp_id", launch_id, 32'd0);
            tick();
        end
        launch_ready = 1'b1;
        run_to_done(60);
        check_output("bp_xfers", 32'(xfer_count), 32'd3);
        check_output("bp_sb_empty", 32'(exp_id_q.size()), 32'd0);
        stop_auto();

        // A start while launching is ignored
        clear_stats();
        launch_ready = 1'b0;
        apply_start(32'd3, 1'b1);
        apply_start(32'd9, 1'b0);
        check_output("ign_busy", 32'(busy), 32'd1);
        check_output("ign_id", launch_id, 32'd0);
        launch_ready = 1'b1;
        auto_retire = 1'b1;
        run_to_done(60);
        check_output("ign_xfers", 32'(xfer_count), 32'd3);
        check_output("ign_sb_empty", 32'(exp_id_q.size()), 32'd0);
        stop_auto();

        // In-flight cap: 40 photons, no retires
        clear_stats();
        launch_ready = 1'b1;
        apply_start(32'd40, 1'b1);
        for (int i = 0; i < 25; i++) tick();
        check_output("cap_xfers", 32'(xfer_count), 32'd16);
        check_output("cap_valid", 32'(launch_valid), 32'd0);
        check_output("cap_inflight", 32'(inflight), 32'd16);
        retire = 1'b1;
        tick();
        retire = 1'b0;
        check_output("cap_after_retire", 32'(inflight), 32'd15);
        for (int i = 0; i < 6; i++) tick();
        check_output("cap_xfers2", 32'(xfer_count), 32'd17);
        check_output("cap_inflight2", 32'(inflight), 32'd16);
        check_output("cap_valid2", 32'(launch_valid), 32'd0);
        check_output("cap_id", launch_id, 32'd17);

        // Reset in DRAIN with 7 outstanding, then a clean 2-photon run
        apply_reset(1);
        clear_stats();
        launch_ready = 1'b1;
        apply_start(32'd7, 1'b1);
        for (int i = 0; i < 12; i++) tick();
        check_output("drain_busy", 32'(busy), 32'd1);
        check_output("drain_valid", 32'(launch_valid), 32'd0);
        check_output("drain_inflight", 32'(inflight), 32'd7);
        apply_reset(1);
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        check_output("mid_rst_done", 32'(done), 32'd0);
        check_output("mid_rst_inflight", 32'(inflight), 32'd0);
        check_output("mid_rst_id", launch_id, 32'd0);
        clear_stats();
        launch_ready = 1'b1;
        auto_retire = 1'b1;
        apply_start(32'd2, 1'b1);
        run_to_done(60);
        check_output("rerun_xfers", 32'(xfer_count), 32'd2);
        check_output("rerun_err", 32'(err_underflow), 32'd0);
        stop_auto();

        // Zero-photon run and stray retires
        clear_stats();
        apply_start(32'd0, 1'b1);
        check_output("zero_done", 32'(done), 32'd1);
        check_output("zero_valid", 32'(launch_valid), 32'd0);
        check_output("zero_busy", 32'(busy), 32'd0);
        tick();
        tick();
        check_output("zero_xfers", 32'(xfer_count), 32'd0);
        apply_reset(1);
        retire = 1'b1;
        tick();
        retire = 1'b0;
        check_output("under_err", 32'(err_underflow), 32'd1);
        check_output("under_inflight", 32'(inflight), 32'd0);
        tick();
        check_output("under_sticky", 32'(err_underflow), 32'd1);
        apply_start(32'd0, 1'b1);
        check_output("start_clears_err", 32'(err_underflow), 32'd0);
        check_output("zero_done2", 32'(done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
